// File: rtl/debounce_pkg.sv
// Shared defaults and the per-channel debounce state type.
package debounce_pkg;

    localparam int DEF_NUM_CH        = 8;
    localparam int DEF_STABLE_CYCLES = 4;
    localparam int DEF_CNT_W         = 8;
    localparam int DEF_PRESCALE      = 1;
    localparam int PRESCALE_W        = 16;

    // STABLE: dout already matches the synchronized input.
    // PENDING: a differing level is being timed.
    typedef enum logic [0:0] {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } db_state_e;

endpackage

// File: rtl/input_debouncer_if.sv
// Raw pad levels in; debounced levels, edge pulses and the prescaler tick out.
interface input_debouncer_if
    import debounce_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH
);
    logic [NUM_CH-1:0] din;
    logic [NUM_CH-1:0] dout;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;
    logic              tick;

    modport master (output din, input dout, input rise, input fall, input tick);
    modport slave  (input din, output dout, output rise, output fall, output tick);
endinterface

// File: rtl/debounce_channel.sv
// One debounce lane: 2-flop synchronizer, tick-gated stability counter and
// a two-state FSM. The output flips on the STABLE_CYCLES-th tick that sees
// the new level, counting the tick of the cycle the mismatch is first seen.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int   CNT_W         = DEF_CNT_W,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);
    localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic             SINGLE_TICK = (STABLE_CYCLES == 1);

    logic             s1_r;
    logic             s2_r;
    logic             dout_r;
    logic             rise_r;
    logic             fall_r;
    logic [CNT_W-1:0] cnt_r;
    db_state_e        state_r;

    logic             mismatch_s;
    logic             dout_s;
    logic             rise_s;
    logic             fall_s;
    logic [CNT_W-1:0] cnt_s;
    db_state_e        state_s;

    assign mismatch_s = (s2_r != dout_r);

    // Next-state logic; a return to the current level always wins over a tick.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        dout_s  = dout_r;
        rise_s  = 1'b0;
        fall_s  = 1'b0;
        case (state_r)
            STABLE: begin
                cnt_s = {CNT_W{1'b0}};
                if (mismatch_s) begin
                    if (tick) begin
                        if (SINGLE_TICK) begin
                            dout_s = s2_r;
                            rise_s = s2_r;
                            fall_s = ~s2_r;
                        end else begin
                            state_s = PENDING;
                            cnt_s   = CNT_ONE;
                        end
                    end else begin
                        state_s = PENDING;
                    end
                end else begin
                    state_s = STABLE;
                end
            end
            PENDING: begin
                if (!mismatch_s) begin
                    state_s = STABLE;
                    cnt_s   = {CNT_W{1'b0}};
                end else if (tick) begin
                    if (cnt_r == LAST_CNT) begin
                        state_s = STABLE;
                        cnt_s   = {CNT_W{1'b0}};
                        dout_s  = s2_r;
                        rise_s  = s2_r;
                        fall_s  = ~s2_r;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = STABLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Synchronizer, FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r    <= RESET_VAL;
            s2_r    <= RESET_VAL;
            dout_r  <= RESET_VAL;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= STABLE;
        end else begin
            s1_r    <= din;
            s2_r    <= s1_r;
            dout_r  <= dout_s;
            rise_r  <= rise_s;
            fall_r  <= fall_s;
            cnt_r   <= cnt_s;
            state_r <= state_s;
        end
    end

    assign dout = dout_r;
    assign rise = rise_r;
    assign fall = fall_r;

endmodule

// File: rtl/input_debouncer.sv
// Debounces NUM_CH raw pad inputs; all lanes share one prescaler tick.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int   NUM_CH        = DEF_NUM_CH,
    parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int   CNT_W         = DEF_CNT_W,
    parameter int   PRESCALE      = DEF_PRESCALE,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input_debouncer_if.slave   bus
);
    localparam logic [PRESCALE_W-1:0] PRE_LAST = PRESCALE_W'(PRESCALE - 1);
    localparam logic [PRESCALE_W-1:0] PRE_ONE  = PRESCALE_W'(1);

    if ((STABLE_CYCLES < 1) || (STABLE_CYCLES >= (1 << CNT_W))) begin : g_bad_stable
        $error("input_debouncer: STABLE_CYCLES must be in 1..2^CNT_W-1");
    end
    if ((PRESCALE < 1) || (PRESCALE > 65535)) begin : g_bad_prescale
        $error("input_debouncer: PRESCALE must be in 1..65535");
    end

    logic [PRESCALE_W-1:0] pre_cnt_r;
    logic                  tick_r;
    logic [NUM_CH-1:0]     dout_s;
    logic [NUM_CH-1:0]     rise_s;
    logic [NUM_CH-1:0]     fall_s;

    // Shared prescaler: counts 0..PRESCALE-1, tick registered on the wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_r <= {PRESCALE_W{1'b0}};
            tick_r    <= 1'b0;
        end else if (pre_cnt_r == PRE_LAST) begin
            pre_cnt_r <= {PRESCALE_W{1'b0}};
            tick_r    <= 1'b1;
        end else begin
            pre_cnt_r <= pre_cnt_r + PRE_ONE;
            tick_r    <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W),
            .RESET_VAL     (RESET_VAL)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .tick (tick_r),
            .din  (bus.din[i]),
            .dout (dout_s[i]),
            .rise (rise_s[i]),
            .fall (fall_s[i])
        );
    end

    assign bus.dout = dout_s;
    assign bus.rise = rise_s;
    assign bus.fall = fall_s;
    assign bus.tick = tick_r;

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench: table of per-cycle vectors on a PRESCALE=1 instance,
// plus a hand-written tick/latency sequence on a PRESCALE=10 instance.
module tb_input_debouncer;
    import debounce_pkg::*;

    localparam int LAT = 6;  // edges from first sampling edge to dout flip (PRESCALE=1, 4 ticks)

    typedef struct {
        logic       rst;
        logic [7:0] din;
        logic [7:0] dout;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       tick;
    } vec_t;

    typedef struct {
        logic [7:0] dout;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       tick;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    input_debouncer_if #(.NUM_CH(8)) a_if ();
    input_debouncer_if #(.NUM_CH(8)) b_if ();

    input_debouncer #(
        .NUM_CH(8), .STABLE_CYCLES(4), .CNT_W(8), .PRESCALE(1), .RESET_VAL(1'b0)
    ) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (a_if)
    );

    input_debouncer #(
        .NUM_CH(8), .STABLE_CYCLES(4), .CNT_W(8), .PRESCALE(10), .RESET_VAL(1'b0)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (b_if)
    );

    function automatic void add(logic r, logic [7:0] d, logic [7:0] o,
                                logic [7:0] ri, logic [7:0] fa);
        vec_t v;
        v.rst  = r;
        v.din  = d;
        v.dout = o;
        v.rise = ri;
        v.fall = fa;
        v.tick = ~r;  // PRESCALE=1: tick high after every non-reset edge
        vecs.push_back(v);
    endfunction

    // Hold din for n edges; outputs flip from prev to nxt on edge LAT.
    function automatic void add_change(logic [7:0] d, logic [7:0] prev,
                                       logic [7:0] nxt, int n);
        for (int k = 1; k <= n; k++) begin
            if (k < LAT)       add(1'b0, d, prev, 8'h00, 8'h00);
            else if (k == LAT) add(1'b0, d, nxt, nxt & ~prev, prev & ~nxt);
            else               add(1'b0, d, nxt, 8'h00, 8'h00);
        end
    endfunction

    task automatic check8(string name, logic [7:0] act, logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        int   cyc;
        int   ticks;
        bit   done;

        a_if.din = 8'h00;
        b_if.din = 8'h00;

        // ---- vector table for instance A ----
        for (int i = 0; i < 3; i++) add(1'b1, 8'hFF, 8'h00, 8'h00, 8'h00);
        add_change(8'hFF, 8'h00, 8'hFF, 7);   // release with all inputs high
        add_change(8'hF6, 8'hFF, 8'hF6, 7);   // bits 3 and 0 released together
        add_change(8'hF7, 8'hF6, 8'hF7, 8);   // clean press on bit 0
        add_change(8'hF6, 8'hF7, 8'hF6, 7);   // release bit 0 again
        add(1'b0, 8'hF7, 8'hF6, 8'h00, 8'h00); // bounce: 1,1,0,0 then settle at 1
        add(1'b0, 8'hF7, 8'hF6, 8'h00, 8'h00);
        add(1'b0, 8'hF6, 8'hF6, 8'h00, 8'h00);
        add(1'b0, 8'hF6, 8'hF6, 8'h00, 8'h00);
        add_change(8'hF7, 8'hF6, 8'hF7, 8);
        add(1'b1, 8'h00, 8'h00, 8'h00, 8'h00); // reset from high levels: no fall
        add(1'b0, 8'hA5, 8'h00, 8'h00, 8'h00); // A5 applied, reset on edge 3
        add(1'b0, 8'hA5, 8'h00, 8'h00, 8'h00);
        add(1'b1, 8'hA5, 8'h00, 8'h00, 8'h00);
        add_change(8'hA5, 8'h00, 8'hA5, 7);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_a    = vecs[i].rst;
            a_if.din = vecs[i].din;
            e.dout = vecs[i].dout;
            e.rise = vecs[i].rise;
            e.fall = vecs[i].fall;
            e.tick = vecs[i].tick;
            sb.push_back(e);
            @(posedge clk);
            #2;
            e = sb.pop_front();
            check8($sformatf("a_dout[%0d]", i), a_if.dout, e.dout);
            check8($sformatf("a_rise[%0d]", i), a_if.rise, e.rise);
            check8($sformatf("a_fall[%0d]", i), a_if.fall, e.fall);
            check8($sformatf("a_tick[%0d]", i), {7'd0, a_if.tick}, {7'd0, e.tick});
            check8($sformatf("a_rise_and_fall[%0d]", i), a_if.rise & a_if.fall, 8'h00);
        end

        // ---- instance B: PRESCALE=10 ----
        @(negedge clk);
        rst_b = 1'b0;
        cyc = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (b_if.tick) break;
        end
        check8("b_first_tick_edge", 8'(cyc), 8'd10);
        cyc = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (b_if.tick) break;
        end
        check8("b_tick_period", 8'(cyc), 8'd10);

        @(negedge clk);
        b_if.din = 8'h20;
        @(posedge clk);  // s1 takes the new level
        @(posedge clk);  // s2 takes the new level
        ticks = 0;
        done  = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check8("b_dout_flip", b_if.dout, e.dout);
                check8("b_rise_flip", b_if.rise, e.rise);
                check8("b_fall_flip", b_if.fall, e.fall);
                done = 1'b1;
            end else begin
                check8("b_dout_hold", b_if.dout, 8'h00);
                check8("b_rise_hold", b_if.rise, 8'h00);
                if (b_if.tick) begin
                    ticks++;
                    if (ticks == 4) begin
                        e.dout = 8'h20;
                        e.rise = 8'h20;
                        e.fall = 8'h00;
                        e.tick = 1'b0;
                        sb.push_back(e);
                    end
                end
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL b_flip_timeout: got no flip expected flip after 4 ticks");
        end
        @(negedge clk);
        check8("b_dout_after", b_if.dout, 8'h20);
        check8("b_rise_after", b_if.rise, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
